// File: rtl/fetch_if.sv
// Fetch unit bus: board controls, instruction memory link and decode handshake.
interface fetch_if #(
    parameter int unsigned PC_WIDTH    = 5,
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                   step_button;
    logic                   run_mode;
    logic                   pc_load;
    logic [PC_WIDTH-1:0]    pc_load_addr;
    logic [31:0]            instruction_in;
    logic                   instr_ready;
    logic [PC_WIDTH-1:0]    pc_address;
    logic                   mem_enable;
    logic [31:0]            instr_out;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   instr_valid;
    logic [COUNT_WIDTH-1:0] fetch_count;

    // Fetch unit side
    modport master (
        input  step_button, run_mode, pc_load, pc_load_addr, instruction_in, instr_ready,
        output pc_address, mem_enable, instr_out, instr_pc, instr_valid, fetch_count
    );

    // Board / memory / decode side
    modport slave (
        output step_button, run_mode, pc_load, pc_load_addr, instruction_in, instr_ready,
        input  pc_address, mem_enable, instr_out, instr_pc, instr_valid, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, debounces the step button, fetches one word
// per FETCH cycle and offers it to decode over valid/ready.
module fetch_unit #(
    parameter int unsigned PC_WIDTH        = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned COUNT_WIDTH     = 8
) (
    input  logic clk,
    input  logic rst_n,
    fetch_if.master bus
);

    localparam int unsigned DB_WIDTH = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic [1:0]             sync_q;
    logic                   stable_q;
    logic [DB_WIDTH-1:0]    db_cnt_q;
    logic                   step_pulse_q;

    state_t                 state_q;
    state_t                 state_d;
    logic                   mem_enable_d;
    logic                   mem_enable_q;

    logic [PC_WIDTH-1:0]    pc_q;
    logic [31:0]            instr_out_q;
    logic [PC_WIDTH-1:0]    instr_pc_q;
    logic                   instr_valid_q;
    logic [COUNT_WIDTH-1:0] fetch_count_q;

    // Synchronize the raw button, then accept a level only after it holds steady
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            stable_q     <= 1'b0;
            db_cnt_q     <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], bus.step_button};
            step_pulse_q <= 1'b0;
            if (sync_q[1] != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_q     <= sync_q[1];
                    db_cnt_q     <= '0;
                    step_pulse_q <= sync_q[1];
                end else begin
                    db_cnt_q <= db_cnt_q + DB_WIDTH'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // FSM state register; mem_enable is registered alongside so it tracks FETCH exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
        end
    end

    // Next-state logic; step pulses outside IDLE simply fall away
    always_comb begin
        state_d      = state_q;
        mem_enable_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.run_mode || step_pulse_q) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    state_d = bus.run_mode ? FETCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_enable_d = (state_d == FETCH);
    end

    // PC update (a jump load beats the post-fetch increment) and instruction capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            if (bus.pc_load) begin
                pc_q <= bus.pc_load_addr;
            end else if (state_q == FETCH) begin
                pc_q <= pc_q + PC_WIDTH'(1);
            end

            if (state_q == FETCH) begin
                instr_out_q   <= bus.instruction_in;
                instr_pc_q    <= pc_q;
                instr_valid_q <= 1'b1;
                fetch_count_q <= fetch_count_q + COUNT_WIDTH'(1);
            end else if ((state_q == HOLD) && bus.instr_ready) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pc_address  = pc_q;
    assign bus.mem_enable  = mem_enable_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
